// File: rtl/codec_init_sequencer.sv
// Codec register-init sequencer: walks a 16-entry init table with a selectable
// sample-rate profile and issues each entry to an I2C write master with retries.
module codec_init_sequencer #(
    parameter int         DATA_WIDTH   = 16,
    parameter int         ADDR_WIDTH   = 8,
    parameter int         LUT_SIZE     = 16,
    parameter int         NUM_PROFILES = 4,
    parameter int         PROFILE_IDX  = 12,
    parameter logic [7:0] DEV_ID       = 8'h34,
    parameter int         RESET_WAIT   = 1000,
    parameter int         MAX_RETRY    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            profile,
    output logic                  wr_req,
    input  logic                  wr_ack,
    input  logic                  wr_err,
    output logic [7:0]            dev_id,
    output logic [7:0]            wr_reg_addr,
    output logic [7:0]            wr_reg_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] err_idx
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int CW = (RESET_WAIT > 1) ? $clog2(RESET_WAIT) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(LUT_SIZE - 1);
    localparam logic [RW-1:0]         RETRY_LAST = RW'(MAX_RETRY);
    localparam logic [CW-1:0]         DELAY_LAST = CW'((RESET_WAIT > 0) ? RESET_WAIT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE, FETCH, REQ, RETRY, ADV, DELAY, DONE, ERROR
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [RW-1:0]           retry_q, retry_d;
    logic [CW-1:0]           delay_q, delay_d;
    logic [1:0]              prof_q, prof_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic [ADDR_WIDTH-1:0]   err_idx_q, err_idx_d;

    function automatic logic [8:0] profile_word(input logic [1:0] p);
        case (p)
            2'd0:    return 9'h005;
            2'd1:    return 9'h185;
            2'd2:    return 9'h035;
            default: return 9'h1B5;
        endcase
    endfunction

    // Word layout is {7-bit register address, 9-bit register data}.
    function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [ADDR_WIDTH-1:0] i,
                                                       input logic [8:0] pw);
        logic [15:0] w;
        case (int'(i))
            0:       w = {7'h0F, 9'h000};
            1:       w = {7'h19, 9'h0FC};
            2:       w = {7'h1A, 9'h1E1};
            3:       w = {7'h2F, 9'h00C};
            4:       w = {7'h22, 9'h100};
            5:       w = {7'h25, 9'h100};
            6:       w = {7'h05, 9'h000};
            7:       w = {7'h02, 9'h179};
            8:       w = {7'h03, 9'h179};
            9:       w = {7'h2B, 9'h050};
            10:      w = {7'h2C, 9'h00A};
            11:      w = {7'h07, 9'h042};
            12:      w = {7'h04, 9'h000};
            13:      w = {7'h34, 9'h028};
            14:      w = {7'h08, 9'h1C4};
            15:      w = {7'h09, 9'h000};
            default: w = 16'h0000;
        endcase
        if (int'(i) == PROFILE_IDX) w[8:0] = pw;
        return DATA_WIDTH'(w);
    endfunction

    // Handshake: wr_req stays high with address/data stable until the master
    // returns a one-cycle wr_ack (ACK) or wr_err (NACK); wr_err wins a tie and
    // either pulse outside REQ is ignored.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        delay_d   = delay_q;
        prof_d    = prof_q;
        word_d    = word_q;
        err_idx_d = err_idx_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d   = FETCH;
                    idx_d     = '0;
                    retry_d   = '0;
                    err_idx_d = '0;
                    prof_d    = (int'(profile) < NUM_PROFILES) ? profile : 2'd0;
                end
            end
            FETCH: begin
                word_d  = rom_word(idx_q, profile_word(prof_q));
                state_d = REQ;
            end
            REQ: begin
                if (wr_err)      state_d = RETRY;
                else if (wr_ack) state_d = ADV;
            end
            RETRY: begin
                if (retry_q == RETRY_LAST) begin
                    state_d   = ERROR;
                    err_idx_d = idx_q;
                end else begin
                    retry_d = retry_q + RW'(1);
                    state_d = FETCH;
                end
            end
            ADV: begin
                retry_d = '0;
                if (idx_q == '0 && RESET_WAIT > 0) begin
                    delay_d = '0;
                    state_d = DELAY;
                end else if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + ADDR_WIDTH'(1);
                    state_d = FETCH;
                end
            end
            DELAY: begin
                // Settle time after the codec soft reset in entry 0.
                if (delay_q == DELAY_LAST) begin
                    if (LUT_SIZE == 1) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = ADDR_WIDTH'(1);
                        state_d = FETCH;
                    end
                end else begin
                    delay_d = delay_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            retry_q   <= '0;
            delay_q   <= '0;
            prof_q    <= '0;
            word_q    <= '0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            delay_q   <= delay_d;
            prof_q    <= prof_d;
            word_q    <= word_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign wr_req      = (state_q == REQ);
    assign busy        = !(state_q == IDLE || state_q == DONE || state_q == ERROR);
    assign done        = (state_q == DONE);
    assign error       = (state_q == ERROR);
    assign dev_id      = DEV_ID;
    assign wr_reg_addr = word_q[DATA_WIDTH-1 -: 8];
    assign wr_reg_data = word_q[7:0];
    assign err_idx     = err_idx_q;

endmodule

// File: tb/tb_codec_init_sequencer.sv
// Bench for codec_init_sequencer: transaction-level model of the init table walk,
// an auto-responding I2C master, and a per-cycle compare process.
module tb_codec_init_sequencer;

    localparam int LUT = 16;
    localparam int RWAIT = 100;
    localparam int MAXR = 3;

    logic       clk = 1'b0;
    logic       rst_n, start, wr_req, wr_ack, wr_err, busy, done, error;
    logic [1:0] profile;
    logic [7:0] dev_id, wr_reg_addr, wr_reg_data, err_idx;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    codec_init_sequencer #(.RESET_WAIT(RWAIT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .profile(profile),
        .wr_req(wr_req), .wr_ack(wr_ack), .wr_err(wr_err), .dev_id(dev_id),
        .wr_reg_addr(wr_reg_addr), .wr_reg_data(wr_reg_data), .busy(busy),
        .done(done), .error(error), .err_idx(err_idx)
    );

    localparam logic [6:0] T_A [16] = '{7'h0F, 7'h19, 7'h1A, 7'h2F, 7'h22, 7'h25, 7'h05, 7'h02,
                                        7'h03, 7'h2B, 7'h2C, 7'h07, 7'h04, 7'h34, 7'h08, 7'h09};
    localparam logic [8:0] T_D [16] = '{9'h000, 9'h0FC, 9'h1E1, 9'h00C, 9'h100, 9'h100, 9'h000, 9'h179,
                                        9'h179, 9'h050, 9'h00A, 9'h042, 9'h000, 9'h028, 9'h1C4, 9'h000};
    localparam logic [8:0] P_W [4] = '{9'h005, 9'h185, 9'h035, 9'h1B5};

    typedef enum {PH_IDLE, PH_RUN, PH_DONE, PH_ERR} phase_t;
    phase_t m_phase = PH_IDLE;
    int m_idx = 0, m_fail = 0, m_prof = 0, exp_gap = 0, resp_cyc = 0, exp_err_idx = 0;
    int n_issue = 0;
    int issue_cnt [16];
    int obs_gap [16];
    logic [7:0] obs_a [16];
    logic [7:0] obs_d [16];
    int resp_q [$];
    int total = 0, bad = 0;
    logic prev_req = 1'b0;

    function automatic void check(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] model_word(int i, int p);
        logic [8:0] d;
        d = (i == 12) ? P_W[p] : T_D[i];
        return {T_A[i], d};
    endfunction

    // Outcome of one write as seen by the master: 0 ACK, 1 NACK, 2 both pulses.
    function automatic void model_update(int code);
        if (code != 0) begin
            m_fail++;
            exp_gap = 2;
            if (m_fail > MAXR) begin
                m_phase = PH_ERR;
                exp_err_idx = m_idx;
            end
        end else begin
            exp_gap = (m_idx == 0 && RWAIT > 0) ? RWAIT + 2 : 2;
            m_fail = 0;
            m_idx++;
            if (m_idx == LUT) m_phase = PH_DONE;
        end
        resp_cyc = cyc;
    endfunction

    task automatic responder();
        int code;
        forever begin
            @(posedge clk); #1;
            if (wr_req) begin
                repeat (2) begin @(posedge clk); #1; end
                if (wr_req) begin
                    code = (resp_q.size() > 0) ? resp_q.pop_front() : 0;
                    wr_ack = (code != 1);
                    wr_err = (code != 0);
                    @(posedge clk); #1;
                    wr_ack = 1'b0;
                    wr_err = 1'b0;
                    model_update(code);
                end
            end
        end
    endtask

    task automatic monitor();
        logic [15:0] w;
        forever begin
            @(negedge clk);
            check("dev_id", int'(dev_id), 'h34);
            if (m_phase == PH_RUN) begin
                check("busy_run", int'(busy), 1);
                check("done_run", int'(done), 0);
                check("error_run", int'(error), 0);
                if (wr_req && m_idx < LUT) begin
                    w = model_word(m_idx, m_prof);
                    check("wr_reg_addr", int'(wr_reg_addr), int'(w[15:8]));
                    check("wr_reg_data", int'(wr_reg_data), int'(w[7:0]));
                    if (!prev_req) begin
                        check("req_gap", cyc - resp_cyc, exp_gap);
                        n_issue++;
                        issue_cnt[m_idx]++;
                        obs_a[m_idx] = wr_reg_addr;
                        obs_d[m_idx] = wr_reg_data;
                        obs_gap[m_idx] = cyc - resp_cyc;
                    end
                end
            end else begin
                check("no_req_outside_run", int'(wr_req), 0);
            end
            prev_req = wr_req;
        end
    endtask

    task automatic start_seq(int p);
        @(posedge clk); #1;
        start = 1'b1;
        profile = 2'(p);
        @(posedge clk); #1;
        start = 1'b0;
        m_phase = PH_RUN;
        m_idx = 0;
        m_fail = 0;
        m_prof = p;
        resp_cyc = cyc;
        exp_gap = 1;
        n_issue = 0;
        for (int i = 0; i < LUT; i++) begin
            issue_cnt[i] = 0;
            obs_gap[i] = 0;
            obs_a[i] = 8'h00;
            obs_d[i] = 8'h00;
        end
    endtask

    task automatic start_ignored(int p);
        @(posedge clk); #1;
        start = 1'b1;
        profile = 2'(p);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done || error) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("seq_end_reached", int'(done || error), 1);
        check("done_end", int'(done), int'(m_phase == PH_DONE));
        check("error_end", int'(error), int'(m_phase == PH_ERR));
        check("busy_end", int'(busy), 0);
        if (m_phase == PH_ERR) check("err_idx_model", int'(err_idx), exp_err_idx);
    endtask

    task automatic wait_idx(int k);
        int n = 0;
        while (!(wr_req && m_idx == k) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("reach_entry", int'(wr_req && m_idx == k), 1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; profile = 2'd0; wr_ack = 1'b0; wr_err = 1'b0;
        for (int i = 0; i < LUT; i++) begin
            issue_cnt[i] = 0; obs_gap[i] = 0; obs_a[i] = 8'h00; obs_d[i] = 8'h00;
        end
        fork
            responder();
            monitor();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_wr_req", int'(wr_req), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_error", int'(error), 0);
        check("rst_err_idx", int'(err_idx), 0);
        check("rst_addr", int'(wr_reg_addr), 0);
        check("rst_data", int'(wr_reg_data), 0);
        check("rst_dev_id", int'(dev_id), 'h34);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", int'(busy), 0);

        // Profile 0, all acked
        start_seq(0);
        wait_end();
        check("p0_done", int'(done), 1);
        check("p0_writes", n_issue, 16);
        check("p0_e0_addr", int'(obs_a[0]), 'h1E);
        check("p0_e0_data", int'(obs_d[0]), 'h00);
        check("p0_e1_addr", int'(obs_a[1]), 'h32);
        check("p0_e1_data", int'(obs_d[1]), 'hFC);
        check("p0_e12_addr", int'(obs_a[12]), 'h08);
        check("p0_e12_data", int'(obs_d[12]), 'h05);
        check("p0_e14_addr", int'(obs_a[14]), 'h11);
        check("p0_e14_data", int'(obs_d[14]), 'hC4);
        check("p0_settle_gap", obs_gap[1], 102);
        check("p0_min_gap", obs_gap[2], 2);

        // Profile 1, then profile 3 with an ignored mid-sequence start
        start_seq(1);
        wait_end();
        check("p1_writes", n_issue, 16);
        check("p1_e12_addr", int'(obs_a[12]), 'h09);
        check("p1_e12_data", int'(obs_d[12]), 'h85);
        check("p1_e13_addr", int'(obs_a[13]), 'h68);
        check("p1_e13_data", int'(obs_d[13]), 'h28);
        start_seq(3);
        wait_idx(5);
        start_ignored(2);
        wait_end();
        check("p3_writes", n_issue, 16);
        check("p3_e12_addr", int'(obs_a[12]), 'h09);
        check("p3_e12_data", int'(obs_d[12]), 'hB5);

        // Two NACKs on entry 3, then ACK
        resp_q = '{0, 0, 0, 1, 1};
        start_seq(0);
        wait_end();
        check("nack2_done", int'(done), 1);
        check("nack2_e3_issues", issue_cnt[3], 3);
        check("nack2_writes", n_issue, 18);

        // Four NACKs on entry 3 -> abort
        resp_q = '{0, 0, 0, 1, 1, 1, 1};
        start_seq(0);
        wait_end();
        check("abort_error", int'(error), 1);
        check("abort_done", int'(done), 0);
        check("abort_err_idx", int'(err_idx), 3);
        check("abort_e3_issues", issue_cnt[3], 4);
        repeat (40) @(negedge clk);
        check("abort_writes", n_issue, 7);
        check("abort_error_sticky", int'(error), 1);

        // ACK and NACK together on entry 2 counts as NACK
        resp_q = '{0, 0, 2};
        start_seq(2);
        wait_end();
        check("both_done", int'(done), 1);
        check("both_e2_issues", issue_cnt[2], 2);
        check("both_writes", n_issue, 17);
        check("p2_e12_addr", int'(obs_a[12]), 'h08);
        check("p2_e12_data", int'(obs_d[12]), 'h35);

        // Asynchronous reset during entry 7's request
        start_seq(0);
        wait_idx(7);
        #1;
        rst_n = 1'b0;
        m_phase = PH_IDLE;
        #1;
        check("arst_wr_req", int'(wr_req), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_addr", int'(wr_reg_addr), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        start_seq(1);
        wait_end();
        check("restart_done", int'(done), 1);
        check("restart_writes", n_issue, 16);
        check("restart_e0_addr", int'(obs_a[0]), 'h1E);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
